// File: rtl/fp_adder_arbiter.sv
// Round-robin sequencer sharing one floating-point adder among NUM_REQ requesters.
// One operation in flight at a time; a watchdog returns qNaN if the adder never answers.
module fp_adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_op,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_accept,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [31:0]            rsp_y,
  output logic                   busy,
  output logic                   timeout_err,
  output logic                   adder_start,
  output logic                   adder_op,
  output logic [31:0]            adder_a,
  output logic [31:0]            adder_b,
  input  logic                   adder_ready,
  input  logic [31:0]            adder_y
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);
  localparam logic [31:0]   QNAN      = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t               state_r;
  logic [IW-1:0]        grant_r;
  logic [IW-1:0]        last_r;
  logic [TW-1:0]        timer_r;
  logic [NUM_REQ-1:0]   req_accept_r;
  logic [NUM_REQ-1:0]   rsp_valid_r;
  logic [31:0]          rsp_y_r;
  logic                 busy_r;
  logic                 timeout_err_r;
  logic                 adder_start_r;
  logic                 adder_op_r;
  logic [31:0]          adder_a_r;
  logic [31:0]          adder_b_r;

  logic [IW-1:0]        cand_s;
  logic                 hit_s;
  logic [IW-1:0]        grant_idx_s;
  logic                 grant_found_s;
  logic [31:0]          sel_a_s;
  logic [31:0]          sel_b_s;
  logic                 sel_op_s;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = {NUM_REQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Rotating-priority search beginning just after the last served requester
  always_comb begin
    grant_idx_s   = last_r;
    grant_found_s = 1'b0;
    cand_s        = last_r;
    hit_s         = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s        = IW'((int'(last_r) + i) % NUM_REQ);
      hit_s         = ~grant_found_s & req_valid[cand_s];
      grant_idx_s   = hit_s ? cand_s : grant_idx_s;
      grant_found_s = grant_found_s | hit_s;
    end
  end

  // Operand mux for the candidate grant
  always_comb begin
    sel_a_s  = 32'h0000_0000;
    sel_b_s  = 32'h0000_0000;
    sel_op_s = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      sel_a_s  = (grant_idx_s == IW'(j)) ? req_a[32*j +: 32] : sel_a_s;
      sel_b_s  = (grant_idx_s == IW'(j)) ? req_b[32*j +: 32] : sel_b_s;
      sel_op_s = (grant_idx_s == IW'(j)) ? req_op[j]         : sel_op_s;
    end
  end

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      grant_r       <= LAST_INIT;
      last_r        <= LAST_INIT;
      timer_r       <= {TW{1'b0}};
      req_accept_r  <= {NUM_REQ{1'b0}};
      rsp_valid_r   <= {NUM_REQ{1'b0}};
      rsp_y_r       <= 32'h0000_0000;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
      adder_start_r <= 1'b0;
      adder_op_r    <= 1'b0;
      adder_a_r     <= 32'h0000_0000;
      adder_b_r     <= 32'h0000_0000;
    end else begin
      rsp_valid_r <= {NUM_REQ{1'b0}};
      case (state_r)
        ST_IDLE: begin
          if (grant_found_s) begin
            grant_r      <= grant_idx_s;
            adder_a_r    <= sel_a_s;
            adder_b_r    <= sel_b_s;
            adder_op_r   <= sel_op_s;
            req_accept_r <= onehot(grant_idx_s);
            busy_r       <= 1'b1;
            state_r      <= ST_ISSUE;
          end else begin
            busy_r       <= 1'b0;
          end
        end
        ST_ISSUE: begin
          adder_start_r <= 1'b1;
          req_accept_r  <= {NUM_REQ{1'b0}};
          timer_r       <= {TW{1'b0}};
          state_r       <= ST_WAIT;
        end
        ST_WAIT: begin
          adder_start_r <= 1'b0;
          if (adder_ready) begin
            rsp_y_r     <= adder_y;
            rsp_valid_r <= onehot(grant_r);
            last_r      <= grant_r;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else if (timer_r == TIMER_MAX) begin
            // Watchdog expiry: answer with a quiet NaN so the requester is never stranded
            rsp_y_r       <= QNAN;
            rsp_valid_r   <= onehot(grant_r);
            timeout_err_r <= 1'b1;
            last_r        <= grant_r;
            busy_r        <= 1'b0;
            state_r       <= ST_IDLE;
          end else begin
            timer_r <= timer_r + TIMER_ONE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_accept  = req_accept_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_y       = rsp_y_r;
  assign busy        = busy_r;
  assign timeout_err = timeout_err_r;
  assign adder_start = adder_start_r;
  assign adder_op    = adder_op_r;
  assign adder_a     = adder_a_r;
  assign adder_b     = adder_b_r;

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Bench for fp_adder_arbiter: a timestamp-based transaction model predicts every output each
// cycle; the bench also plays the adder and the requesters, with directed and random phases.
module tb_fp_adder_arbiter;

  localparam int N       = 4;
  localparam int TO      = 64;
  localparam int NEVER   = -1;
  localparam int NOFORCE = -100;
  localparam int INF     = 32'h7FFF_FFFF;
  localparam int MODE_DIR  = 0;
  localparam int MODE_HOLD = 1;
  localparam int MODE_RAND = 2;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_op;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [N-1:0]   req_accept;
  logic [N-1:0]   rsp_valid;
  logic [31:0]    rsp_y;
  logic           busy;
  logic           timeout_err;
  logic           adder_start;
  logic           adder_op;
  logic [31:0]    adder_a;
  logic [31:0]    adder_b;
  logic           adder_ready;
  logic [31:0]    adder_y;

  fp_adder_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_accept(req_accept), .rsp_valid(rsp_valid), .rsp_y(rsp_y),
    .busy(busy), .timeout_err(timeout_err),
    .adder_start(adder_start), .adder_op(adder_op), .adder_a(adder_a), .adder_b(adder_b),
    .adder_ready(adder_ready), .adder_y(adder_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int mode   = MODE_DIR;

  // Transaction model: one operation described by the cycles its events must appear in
  bit          m_active = 1'b0;
  int          m_last = N - 1;
  int          m_g = 0;
  int          m_acc_cyc = 0, m_start_cyc = 0, m_ready_cyc = -1, m_rsp_cyc = 0;
  int          m_terr_from = INF;
  logic [31:0] m_rsp_val = 32'h0, m_a = 32'h0, m_b = 32'h0;
  logic        m_op = 1'b0;

  int          force_lat = NOFORCE;
  logic [31:0] force_y = 32'h0;
  bit          force_y_en = 1'b0;
  int          stray_cyc = -1;
  int          stray_pct = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int i);
    logic [3:0] v;
    v = 4'b0001 << i;
    return v;
  endfunction

  function automatic int idx_of(input logic [3:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic bit m_idle();
    return !m_active || cyc >= m_rsp_cyc;
  endfunction

  function automatic bit m_in_wait();
    return m_active && cyc >= m_start_cyc && cyc < m_rsp_cyc;
  endfunction

  task automatic set_ops(input int idx, input logic op, input logic [31:0] a, input logic [31:0] b);
    req_a = (req_a & ~(128'hFFFF_FFFF << (32*idx))) | (128'(a) << (32*idx));
    req_b = (req_b & ~(128'hFFFF_FFFF << (32*idx))) | (128'(b) << (32*idx));
    req_op[2'(idx)] = op;
  endtask

  function automatic int pick_lat();
    int r;
    if (force_lat != NOFORCE) begin
      r = force_lat;
      force_lat = NOFORCE;
      return r;
    end
    if (mode == MODE_HOLD) return int'($urandom_range(0, 6));
    r = int'($urandom_range(0, 99));
    if (r < 80) return int'($urandom_range(0, 8));
    if (r < 90) return int'($urandom_range(TO - 4, TO - 1));
    return NEVER;
  endfunction

  // Apply this cycle's inputs to the model (what the coming clock edge must do)
  task automatic model_update();
    int g;
    int lat;
    if (!rst) begin
      m_active = 1'b0; m_last = N - 1; m_terr_from = INF;
      m_a = 32'h0; m_b = 32'h0; m_op = 1'b0;
    end else if (m_idle() && req_valid != 4'b0000) begin
      g = -1;
      for (int k = 1; k <= N; k++)
        if (g < 0 && req_valid[2'((m_last + k) % N)]) g = (m_last + k) % N;
      m_g = g; m_last = g; m_active = 1'b1;
      m_acc_cyc = cyc + 1; m_start_cyc = cyc + 2;
      m_a  = 32'(req_a >> (32*g));
      m_b  = 32'(req_b >> (32*g));
      m_op = req_op[2'(g)];
      lat = pick_lat();
      if (lat >= 0 && lat < TO) begin
        m_ready_cyc = cyc + 2 + lat;
        m_rsp_cyc   = m_ready_cyc + 1;
        m_rsp_val   = force_y_en ? force_y : $urandom;
      end else begin
        m_ready_cyc = -1;
        m_rsp_cyc   = cyc + 2 + TO;
        m_rsp_val   = 32'h7FC0_0000;
        if (m_rsp_cyc < m_terr_from) m_terr_from = m_rsp_cyc;
      end
      force_y_en = 1'b0;
    end
  endtask

  task automatic drive_adder();
    adder_ready = 1'b0;
    adder_y     = $urandom;
    if (m_in_wait() && cyc == m_ready_cyc) begin
      adder_ready = 1'b1;
      adder_y     = m_rsp_val;
    end else if (!m_in_wait() && (cyc == stray_cyc || int'($urandom_range(0, 99)) < stray_pct)) begin
      adder_ready = 1'b1;
    end
  endtask

  task automatic drive_reqs();
    if (mode != MODE_DIR) begin
      for (int i = 0; i < N; i++) begin
        if (!rst) begin
          req_valid[2'(i)] = 1'b0;
        end else if (req_valid[2'(i)] && req_accept[2'(i)]) begin
          if (mode == MODE_HOLD) set_ops(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
          else req_valid[2'(i)] = 1'b0;
        end else if (!req_valid[2'(i)] && mode == MODE_RAND && $urandom_range(0, 99) < 15) begin
          set_ops(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
          req_valid[2'(i)] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [3:0] e_acc;
    logic [3:0] e_rv;
    e_acc = (m_active && cyc == m_acc_cyc) ? oh(m_g) : 4'b0000;
    e_rv  = (m_active && cyc == m_rsp_cyc) ? oh(m_g) : 4'b0000;
    chk("req_accept", req_accept, e_acc);
    chk("rsp_valid", rsp_valid, e_rv);
    if (e_rv != 4'b0000) chk("rsp_y", rsp_y, m_rsp_val);
    chk("adder_start", adder_start, m_active && cyc == m_start_cyc);
    chk("busy", busy, m_active && cyc >= m_acc_cyc && cyc < m_rsp_cyc);
    chk("timeout_err", timeout_err, cyc >= m_terr_from);
    chk("adder_a", adder_a, m_a);
    chk("adder_b", adder_b, m_b);
    chk("adder_op", adder_op, m_op);
  endtask

  task automatic cycle_end();
    drive_adder();
    drive_reqs();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      if (m_idle() && busy == 1'b0) break;
      cycle_end();
    end
    chk("drain_busy", busy, 32'd0);
  endtask

  task automatic directed(input int idx, input logic op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] y, input int wait_n,
                          input logic [3:0] exp_acc, input logic [31:0] exp_y);
    set_ops(idx, op, a, b);
    req_valid[2'(idx)] = 1'b1;
    force_lat = lat; force_y = y; force_y_en = 1'b1;
    cycle_end();
    chk("dir_accept", req_accept, exp_acc);
    req_valid[2'(idx)] = 1'b0;
    cycle_end();
    chk("dir_start", adder_start, 32'd1);
    chk("dir_adder_a", adder_a, a);
    chk("dir_adder_b", adder_b, b);
    chk("dir_adder_op", adder_op, op);
    repeat (wait_n) cycle_end();
    chk("dir_rsp_valid", rsp_valid, exp_acc);
    chk("dir_rsp_y", rsp_y, exp_y);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog cycle %0d got stuck expected finish", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    int q[$];
    int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    rst = 1'b0; req_valid = 4'b0000; req_op = 4'b0000;
    req_a = 128'h0; req_b = 128'h0; adder_ready = 1'b0; adder_y = 32'h0;
    repeat (3) cycle_end();
    chk("reset_accept", req_accept, 32'd0);
    chk("reset_rsp_valid", rsp_valid, 32'd0);
    chk("reset_rsp_y", rsp_y, 32'd0);
    chk("reset_busy", busy, 32'd0);
    chk("reset_terr", timeout_err, 32'd0);
    chk("reset_start", adder_start, 32'd0);
    rst = 1'b1;
    cycle_end();

    directed(1, 1'b0, 32'h3FC0_0000, 32'h4010_0000, 3, 32'h4070_0000, 4, 4'b0010, 32'h4070_0000);
    directed(0, 1'b1, 32'h4040_0000, 32'h3F80_0000, 0, 32'h4000_0000, 1, 4'b0001, 32'h4000_0000);
    directed(2, 1'b0, 32'h1111_2222, 32'h3333_4444, NEVER, 32'h0, 64, 4'b0100, 32'h7FC0_0000);
    chk("timeout_err_set", timeout_err, 32'd1);
    directed(3, 1'b1, 32'h5555_6666, 32'h7777_8888, 63, 32'h1234_5678, 64, 4'b1000, 32'h1234_5678);
    chk("timeout_err_sticky", timeout_err, 32'd1);

    // Request arriving during WAIT is held off until the running operation returns
    set_ops(0, 1'b0, $urandom, $urandom);
    req_valid[0] = 1'b1;
    force_lat = 10; force_y = 32'hCAFE_0001; force_y_en = 1'b1;
    cycle_end();
    chk("holdoff_accept0", req_accept, 32'd1);
    req_valid[0] = 1'b0;
    cycle_end();
    set_ops(2, 1'b1, $urandom, $urandom);
    req_valid[2] = 1'b1;
    n = 0;
    while (1) begin
      cycle_end();
      n++;
      if (rsp_valid != 4'b0000 || n > 40) break;
      chk("holdoff_no_accept", req_accept, 32'd0);
    end
    chk("holdoff_rsp0", rsp_valid, 32'd1);
    chk("holdoff_rsp0_y", rsp_y, 32'hCAFE_0001);
    cycle_end();
    chk("holdoff_accept2", req_accept, 32'd4);
    req_valid[2] = 1'b0;
    drain();

    // Reset in the middle of WAIT, then a stray ready afterwards
    set_ops(0, 1'b1, $urandom, $urandom);
    req_valid[0] = 1'b1;
    force_lat = NEVER;
    cycle_end();
    req_valid[0] = 1'b0;
    cycle_end();
    cycle_end();
    rst = 1'b0;
    cycle_end();
    chk("midrst_accept", req_accept, 32'd0);
    chk("midrst_rsp_valid", rsp_valid, 32'd0);
    chk("midrst_rsp_y", rsp_y, 32'd0);
    chk("midrst_busy", busy, 32'd0);
    chk("midrst_terr", timeout_err, 32'd0);
    chk("midrst_start", adder_start, 32'd0);
    chk("midrst_op", adder_op, 32'd0);
    chk("midrst_a", adder_a, 32'd0);
    chk("midrst_b", adder_b, 32'd0);
    rst = 1'b1;
    stray_cyc = cyc + 2;
    repeat (6) begin
      cycle_end();
      chk("midrst_no_rsp", rsp_valid, 32'd0);
      chk("midrst_idle", busy, 32'd0);
    end

    // Fairness from reset with all requesters continuously valid
    rst = 1'b0;
    cycle_end();
    cycle_end();
    rst = 1'b1;
    for (int i = 0; i < N; i++) set_ops(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
    req_valid = 4'b1111;
    mode = MODE_HOLD;
    for (int k = 0; k < 2000 && q.size() < 8; k++) begin
      cycle_end();
      if (req_accept != 4'b0000) q.push_back(idx_of(req_accept));
    end
    mode = MODE_DIR;
    req_valid = 4'b0000;
    chk("fair_count", q.size(), 32'd8);
    for (int i = 0; i < 8 && i < q.size(); i++) chk("fair_order", q[i], exp_order[i]);
    drain();

    // Random traffic with stray readies, timeouts and occasional resets
    mode = MODE_RAND;
    stray_pct = 5;
    for (int k = 0; k < 4000; k++) begin
      rst = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
      cycle_end();
    end
    rst = 1'b1;
    mode = MODE_DIR;
    req_valid = 4'b0000;
    stray_pct = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
